// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: shared repeat-state encoding and counter sizing helpers.
package input_conditioner_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, REPEAT} rpt_state_t;
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/input_conditioner_channel.sv
// cond_channel: one input channel -- synchronizer, debouncer, edge pulses and auto-repeat.
module cond_channel
   import input_conditioner_pkg::*;
#(
   parameter int NSYNC           = 3,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_PERIOD   = 10_000_000
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic raw_in,
   input  logic repeat_en,
   output logic level_out,
   output logic rise_out,
   output logic fall_out,
   output logic repeat_out
);
   localparam int DW = cnt_width(DEBOUNCE_CYCLES);
   localparam int RW = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
   logic [NSYNC-1:0] sync;
   logic [DW-1:0] cnt;
   logic [RW-1:0] rpt;
   logic sync_c, cand, lvl_nxt, rise_nxt, fall_nxt;
   rpt_state_t state;
   assign sync_c   = sync[NSYNC-1];
   assign lvl_nxt  = (sync_c == cand && cnt == DB_LAST) ? cand : level_out;
   assign rise_nxt = lvl_nxt & ~level_out;
   assign fall_nxt = ~lvl_nxt & level_out;
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sync      <= '0;
         cand      <= 1'b0;
         cnt       <= '0;
         level_out <= 1'b0;
         rise_out  <= 1'b0;
         fall_out  <= 1'b0;
      end else begin
         sync      <= {sync[NSYNC-2:0], raw_in};
         cand      <= sync_c;
         cnt       <= (sync_c != cand) ? '0 : (cnt == DB_LAST) ? cnt : cnt + 1'b1;
         level_out <= lvl_nxt;
         rise_out  <= rise_nxt;
         fall_out  <= fall_nxt;
      end
   end
   // a low next level (including a fall) always wins over a due repeat pulse
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state      <= IDLE;
         rpt        <= '0;
         repeat_out <= 1'b0;
      end else begin
         repeat_out <= 1'b0;
         if (!lvl_nxt) begin
            state <= IDLE;
            rpt   <= '0;
         end else if (rise_nxt) begin
            state      <= WAIT;
            rpt        <= '0;
            repeat_out <= 1'b1;
         end else if (!repeat_en) begin
            state <= WAIT;
            rpt   <= '0;
         end else begin
            case (state)
               WAIT: begin
                  state      <= (rpt == RD_LAST) ? REPEAT : WAIT;
                  rpt        <= (rpt == RD_LAST) ? '0 : rpt + 1'b1;
                  repeat_out <= (rpt == RD_LAST);
               end
               REPEAT: begin
                  rpt        <= (rpt == RP_LAST) ? '0 : rpt + 1'b1;
                  repeat_out <= (rpt == RP_LAST);
               end
               default: begin
                  state <= IDLE;
                  rpt   <= '0;
               end
            endcase
         end
      end
   end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: conditions NCH asynchronous inputs into clean levels, edge pulses and auto-repeat.
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int NCH             = 5,
   parameter int NSYNC           = 3,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_PERIOD   = 10_000_000
) (
   input  logic           clk_in,
   input  logic           rst_in,
   input  logic [NCH-1:0] raw_in,
   input  logic [NCH-1:0] repeat_en,
   output logic [NCH-1:0] level_out,
   output logic [NCH-1:0] rise_out,
   output logic [NCH-1:0] fall_out,
   output logic [NCH-1:0] repeat_out
);
   for (genvar g = 0; g < NCH; g++) begin : gen_ch
      cond_channel #(
         .NSYNC(NSYNC),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY(REPEAT_DELAY),
         .REPEAT_PERIOD(REPEAT_PERIOD)
      ) u_ch (
         .clk_in(clk_in),
         .rst_in(rst_in),
         .raw_in(raw_in[g]),
         .repeat_en(repeat_en[g]),
         .level_out(level_out[g]),
         .rise_out(rise_out[g]),
         .fall_out(fall_out[g]),
         .repeat_out(repeat_out[g])
      );
   end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed stimulus with a pulse-event scoreboard for input_conditioner.
module tb_input_conditioner;
   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   logic [1:0] raw_in = 2'b00;
   logic [1:0] repeat_en = 2'b00;
   logic [1:0] level_out, rise_out, fall_out, repeat_out;
   int cyc = 0;
   int total = 0;
   int bad = 0;
   int r;
   typedef struct {
      int         cyc;
      logic [7:0] v;
   } ev_t;
   ev_t sb[$];
   // event vector layout: {rise, fall, repeat, level}
   localparam logic [7:0] RISE0 = 8'b01_00_01_01;
   localparam logic [7:0] RPT0  = 8'b00_00_01_01;
   localparam logic [7:0] FALL0 = 8'b00_01_00_00;
   localparam logic [7:0] RISE1 = 8'b10_00_10_10;
   localparam logic [7:0] FALL1 = 8'b00_10_00_00;

   input_conditioner #(
      .NCH(2), .NSYNC(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .raw_in(raw_in),
      .repeat_en(repeat_en),
      .level_out(level_out),
      .rise_out(rise_out),
      .fall_out(fall_out),
      .repeat_out(repeat_out)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic push(input int c, input logic [7:0] v);
      sb.push_back('{cyc: c, v: v});
   endtask

   always @(negedge clk_in) begin
      if (|{rise_out, fall_out, repeat_out}) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: got %b at cycle %0d expected no pulse",
                     {rise_out, fall_out, repeat_out, level_out}, cyc);
         end else begin
            ev_t e;
            e = sb.pop_front();
            check("event_cycle", cyc, e.cyc);
            check("event_outputs", {24'd0, rise_out, fall_out, repeat_out, level_out}, {24'd0, e.v});
         end
      end
   end

   initial begin
      step(3);
      check("reset_state", {24'd0, rise_out, fall_out, repeat_out, level_out}, 32'd0);
      rst_in = 1'b0;
      step(2);
      check("idle_state", {24'd0, rise_out, fall_out, repeat_out, level_out}, 32'd0);
      // qualification latency on channel 0, channel 1 stays quiet
      raw_in = 2'b01;
      push(cyc + 7, RISE0);
      step(9);
      check("held_level", {28'd0, level_out, rise_out}, 32'b0100);
      raw_in = 2'b00;
      push(cyc + 7, FALL0);
      step(10);
      // glitch of 4 cycles is rejected
      raw_in = 2'b01;
      step(4);
      raw_in = 2'b00;
      step(12);
      check("glitch4_level", {30'd0, level_out}, 32'd0);
      // 5 cycles is accepted
      raw_in = 2'b01;
      push(cyc + 7, RISE0);
      step(5);
      raw_in = 2'b00;
      push(cyc + 7, FALL0);
      step(12);
      check("glitch5_level", {30'd0, level_out}, 32'd0);
      // channel 1 alone
      raw_in = 2'b10;
      push(cyc + 7, RISE1);
      step(10);
      check("ch1_level", {30'd0, level_out}, 32'b10);
      raw_in = 2'b00;
      push(cyc + 7, FALL1);
      step(10);
      // auto-repeat with fall landing on a due pulse
      repeat_en = 2'b11;
      raw_in = 2'b01;
      r = cyc + 7;
      push(r, RISE0);
      push(r + 8, RPT0);
      push(r + 11, RPT0);
      push(r + 14, RPT0);
      push(r + 17, RPT0);
      step(20);
      raw_in = 2'b00;
      push(r + 20, FALL0);
      step(10);
      // repeat disabled, then enabled at offset 10
      repeat_en = 2'b00;
      raw_in = 2'b01;
      r = cyc + 7;
      push(r, RISE0);
      step(17);
      repeat_en = 2'b01;
      push(r + 18, RPT0);
      push(r + 21, RPT0);
      push(r + 24, RPT0);
      step(10);
      raw_in = 2'b00;
      push(r + 27, FALL0);
      step(12);
      // asynchronous reset while held
      raw_in = 2'b01;
      r = cyc + 7;
      push(r, RISE0);
      step(12);
      check("pre_reset_level", {30'd0, level_out}, 32'b01);
      #2;
      rst_in = 1'b1;
      #1;
      check("async_reset", {24'd0, rise_out, fall_out, repeat_out, level_out}, 32'd0);
      step(2);
      rst_in = 1'b0;
      r = cyc;
      push(r + 7, RISE0);
      push(r + 15, RPT0);
      step(10);
      raw_in = 2'b00;
      push(r + 17, FALL0);
      step(12);
      check("final_level", {30'd0, level_out}, 32'd0);
      while (sb.size() > 0) begin
         ev_t e;
         e = sb.pop_front();
         total++;
         bad++;
         $display("FAIL missing_event: got nothing expected %b at cycle %0d", e.v, e.cyc);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Parametrised successor to the per-signal synchronizer, debouncer and edge-detector chain used for buttons and switches. It conditions NCH asynchronous inputs in one block; each channel gets a synchronizer, a debouncer, a clean level, and rise/fall pulses. It also adds a per-channel auto-repeat pulse, so menu up/down scrolling continues while a button is held. It sits between board pins (or FFT hi/lo flags) and the menu/game FSMs, all on clk_in.

Parameters:
NCH, 5, number of independent channels (>=1)
NSYNC, 3, synchronizer flop stages (>=2)
DEBOUNCE_CYCLES, 1_000_000, cycles the synchronized input must be stable before level changes (>=1)
REPEAT_DELAY, 50_000_000, cycles from the rise pulse to the first auto-repeat pulse (>=1)
REPEAT_PERIOD, 10_000_000, cycles between subsequent auto-repeat pulses (>=1)

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset; asynchronous and active-high
raw_in  input  NCH  unsynchronized noisy inputs
repeat_en  input  NCH  per-channel auto-repeat enable (synchronous to clk_in)
level_out  output  NCH  debounced level
rise_out  output  NCH  1-cycle pulse on debounced 0->1
fall_out  output  NCH  1-cycle pulse on debounced 1->0
repeat_out  output  NCH  rise pulse plus auto-repeat pulses while held

Behaviour:
- Reset (async, asserted): all sync flops, candidates, counters and outputs clear to 0 immediately. Channels never sample the input at reset, so level_out is 0 after reset.
- Synchronizer: NSYNC-stage shift per channel. sync_c is the last stage.
- Debounce, per channel, evaluated in priority order each edge:
  - If sync_c != cand_c: cand_c <= sync_c and cnt_c <= 0.
  - Else if cnt_c == DEBOUNCE_CYCLES-1: level_c <= cand_c, and cnt_c holds.
  - Else cnt_c increments.
- Debounce counter width is $clog2(DEBOUNCE_CYCLES+1). No wrap is possible.
- Latency: a stable raw change shows on level_out NSYNC+DEBOUNCE_CYCLES+1 edges later.
- Glitch filtering at sync_c: a pulse lasting <= DEBOUNCE_CYCLES cycles is rejected; one lasting >= DEBOUNCE_CYCLES+1 cycles is accepted.
- Edge pulses:
  - rise_out/fall_out are registered and assert in the same cycle that level_out first shows the new value.
  - Each lasts exactly one cycle.
  - Never both high on one channel.
- Auto-repeat, per channel, uses hold counter rpt_c with width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1). States:
  - IDLE (level 0): rpt_c=0, repeat_out=0.
  - ON rise: repeat_out pulses together with rise_out, regardless of repeat_en. Go to WAIT with rpt_c=0.
  - WAIT (level 1, repeat_en 1): rpt_c increments. At REPEAT_DELAY cycles after the rise pulse, pulse repeat_out, reload rpt_c=0, go to REPEAT.
  - REPEAT: a pulse every REPEAT_PERIOD cycles after the previous pulse.
  - repeat_en low while held: rpt_c held at 0 in WAIT, so no repeat pulses. When repeat_en rises again, the first pulse comes REPEAT_DELAY cycles later.
  - Fall in any state: return to IDLE. If a due repeat pulse coincides with the fall, the fall wins and no repeat pulse is emitted.
- Channels are fully independent, so simultaneous events on different channels do not interact.
- Reset mid-operation: outputs drop in the same cycle reset asserts. Pending counts are lost. A still-held raw input re-qualifies after reset release with full latency and produces a fresh rise.

Decomposition:
- Package input_conditioner_pkg holds the repeat FSM state enum (IDLE, WAIT, REPEAT) and the width helper function.
- Natural sub-module: cond_channel (one channel: sync, debounce, edges, repeat), instantiated NCH times in a generate loop.
- The top level only fans out the vectors.

Test Plan:
All scenarios use NCH=2, NSYNC=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3 unless noted.
- Reset then idle: rst_in held 3 cycles, raw_in=2'b00 -> all outputs 0. Asserting rst_in mid-cycle clears outputs without waiting for a clock edge.
- Qualification latency: raw_in[0] 0->1 held -> level_out[0]=1 and rise_out[0]=1 exactly 7 edges later. rise_out is high for 1 cycle. Channel 1 is unaffected.
- Glitch filter: raw_in[0] high 4 cycles -> no level change. High 5 cycles -> level_out rises and then falls, with one rise_out and one fall_out pulse.
- Auto-repeat: repeat_en=1, hold raw_in[0] -> repeat_out[0] pulses at offsets 0, 8, 11, 14, 17 relative to rise_out. Releasing so the fall lands at offset 20 -> no pulse at offset 20.
- Repeat disabled: repeat_en=0, hold 30 cycles -> exactly one repeat_out pulse, coincident with rise_out. Setting repeat_en=1 at offset 10 -> next pulse at offset 18.
- Reset mid-hold: assert rst_in at offset 5 while raw_in is held high, release it -> level_out=0 immediately. Rise reappears 7 edges after release.
